// File: rtl/lamp_pkg.sv
// Shared lamp-bus definitions: legal one-hot codes, phase encodings and
// the checker state encoding.
package lamp_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b001;

  typedef enum logic [1:0] {
    PH_RED    = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } chk_state_e;

endpackage

// File: rtl/lamp_decode.sv
// Combinational lamp-bus decoder: legality, phase number and the code that
// must follow the sampled one.
module lamp_decode
  import lamp_pkg::*;
(
  input  logic [0:2] light,
  output logic       legal,
  output logic [1:0] phase,
  output logic [0:2] succ_code
);

  always_comb begin
    legal     = 1'b0;
    phase     = PH_RED;
    succ_code = '0;
    case (light)
      RED: begin
        legal     = 1'b1;
        phase     = PH_RED;
        succ_code = GREEN;
      end
      GREEN: begin
        legal     = 1'b1;
        phase     = PH_GREEN;
        succ_code = YELLOW;
      end
      YELLOW: begin
        legal     = 1'b1;
        phase     = PH_YELLOW;
        succ_code = RED;
      end
      default: begin
        legal     = 1'b0;
        phase     = PH_RED;
        succ_code = '0;
      end
    endcase
  end

endmodule

// File: rtl/lamp_sequence_checker.sv
// Receive-side lamp protocol checker: tracks RED->GREEN->YELLOW order, dwell and
// completed cycles. Define LAMP_CHK_DWELL_EN to enable MIN/MAX dwell checking.
//
// state | meaning
// HUNT  | waiting for the first legal code
// TRACK | locked to the sequence, checking each sample
// FAULT | a violation was seen; waits for clear
module lamp_sequence_checker
  import lamp_pkg::*;
#(
  parameter int unsigned MIN_DWELL = 1,
  parameter int unsigned MAX_DWELL = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [0:2]       light,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic [CNT_W-1:0] dwell,
  output logic [CNT_W-1:0] cycle_count,
  output logic             fault,
  output logic             illegal_code,
  output logic             seq_err,
  output logic             dwell_err
);

`ifdef LAMP_CHK_DWELL_EN
  localparam bit DWELL_CHK = 1'b1;
`else
  localparam bit DWELL_CHK = 1'b0;
`endif

  chk_state_e       state_q, state_d;
  logic [0:2]       prev_q, prev_d;
  logic [0:2]       next_q, next_d;
  logic [1:0]       phase_q, phase_d;
  logic             pvalid_q, pvalid_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic             ill_q, ill_d;
  logic             seq_q, seq_d;
  logic             dwe_q, dwe_d;
  logic             fault_q, fault_d;

  logic             legal_c;
  logic [1:0]       phase_c;
  logic [0:2]       succ_c;

  lamp_decode u_decode (
    .light     (light),
    .legal     (legal_c),
    .phase     (phase_c),
    .succ_code (succ_c)
  );

  // next_q caches succ(prev) so the successor test is a plain compare.
  logic             is_same, is_succ;
  logic [CNT_W-1:0] dwell_inc;
  logic             over_max, under_min;
  logic             ev_illegal, ev_dwell, ev_seq, trk_fault;

  always_comb begin
    is_same    = (light == prev_q);
    is_succ    = (light == next_q);
    dwell_inc  = (dwell_q == {CNT_W{1'b1}}) ? dwell_q : dwell_q + CNT_W'(1);
    over_max   = DWELL_CHK && is_same && (32'(dwell_inc) > MAX_DWELL);
    under_min  = DWELL_CHK && is_succ && (32'(dwell_q) < MIN_DWELL);
    ev_illegal = !legal_c;
    ev_dwell   = legal_c && (over_max || under_min);
    ev_seq     = legal_c && !is_same && !is_succ;
    trk_fault  = ev_illegal || ev_dwell || ev_seq;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= HUNT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = HUNT;
    end else begin
      case (state_q)
        HUNT:    if (legal_c) state_d = TRACK;
        TRACK:   if (trk_fault) state_d = FAULT;
        FAULT:   state_d = FAULT;
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    prev_d   = prev_q;
    next_d   = next_q;
    phase_d  = phase_q;
    pvalid_d = pvalid_q;
    dwell_d  = dwell_q;
    cyc_d    = cyc_q;
    ill_d    = ill_q;
    seq_d    = seq_q;
    dwe_d    = dwe_q;
    if (clear) begin
      prev_d   = '0;
      next_d   = '0;
      pvalid_d = 1'b0;
      dwell_d  = '0;
      cyc_d    = '0;
      ill_d    = 1'b0;
      seq_d    = 1'b0;
      dwe_d    = 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          if (legal_c) begin
            prev_d   = light;
            next_d   = succ_c;
            phase_d  = phase_c;
            dwell_d  = CNT_W'(1);
            pvalid_d = 1'b1;
          end
        end
        TRACK: begin
          if (ev_illegal) begin
            ill_d    = 1'b1;
            pvalid_d = 1'b0;
          end else if (is_same) begin
            dwell_d = dwell_inc;
            if (over_max) begin
              dwe_d    = 1'b1;
              pvalid_d = 1'b0;
            end
          end else if (is_succ) begin
            if (under_min) begin
              dwe_d    = 1'b1;
              pvalid_d = 1'b0;
            end else begin
              prev_d  = light;
              next_d  = succ_c;
              phase_d = phase_c;
              dwell_d = CNT_W'(1);
              if (prev_q == YELLOW) cyc_d = cyc_q + CNT_W'(1);
            end
          end else begin
            seq_d    = 1'b1;
            pvalid_d = 1'b0;
          end
        end
        FAULT: begin
          pvalid_d = 1'b0;
        end
        default: begin
          pvalid_d = 1'b0;
        end
      endcase
    end
    fault_d = ill_d || seq_d || dwe_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q   <= '0;
      next_q   <= '0;
      phase_q  <= '0;
      pvalid_q <= 1'b0;
      dwell_q  <= '0;
      cyc_q    <= '0;
      ill_q    <= 1'b0;
      seq_q    <= 1'b0;
      dwe_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      prev_q   <= prev_d;
      next_q   <= next_d;
      phase_q  <= phase_d;
      pvalid_q <= pvalid_d;
      dwell_q  <= dwell_d;
      cyc_q    <= cyc_d;
      ill_q    <= ill_d;
      seq_q    <= seq_d;
      dwe_q    <= dwe_d;
      fault_q  <= fault_d;
    end
  end

  assign phase        = phase_q;
  assign phase_valid  = pvalid_q;
  assign dwell        = dwell_q;
  assign cycle_count  = cyc_q;
  assign fault        = fault_q;
  assign illegal_code = ill_q;
  assign seq_err      = seq_q;
  assign dwell_err    = dwe_q;

endmodule
